jt12_acc_sched: RTL

- Slot sequencer and configurator for the time-multiplexed single-accumulator mixer pair (left/right).
- Walks the operator slots of all FM channels and drives the per-slot controls for both accumulators: sum enables, round-start zero pulse and sample strobe.
- Sum enables are derived from each channel's algorithm (carrier map), pan and mute.
- Configuration is double-buffered and committed only at round boundaries, so a mix round never sees a half-updated channel.

---
 rtl/jt12_mix_pkg.sv | 35 +++
 rtl/jt12_acc_cfg_bank.sv | 57 +++++
 rtl/jt12_acc_sched.sv | 73 +++++++
 3 files changed

// File: rtl/jt12_mix_pkg.sv
// Shared constants, per-channel config record and carrier map for the
// time-multiplexed left/right accumulator mixer.
package jt12_mix_pkg;

  localparam int NUM_CH = 6;
  localparam int NUM_OP = 4;
  localparam int SLOTS  = NUM_CH * NUM_OP;

  // Operator slots are presented in time order S1, S3, S2, S4
  localparam logic [1:0] OP_S1 = 2'd0;
  localparam logic [1:0] OP_S3 = 2'd1;
  localparam logic [1:0] OP_S2 = 2'd2;
  localparam logic [1:0] OP_S4 = 2'd3;

  typedef struct packed {
    logic [2:0] alg;
    logic [1:0] pan;
    logic       mute;
  } ch_cfg_t;

  localparam ch_cfg_t CFG_RESET = '{alg: 3'd0, pan: 2'b11, mute: 1'b0};

  function automatic logic is_carrier(input logic [2:0] alg, input logic [1:0] op);
    logic c_s;
    case (op)
      OP_S4:   c_s = 1'b1;
      OP_S2:   c_s = (alg >= 3'd4);
      OP_S3:   c_s = (alg >= 3'd5);
      OP_S1:   c_s = (alg == 3'd7);
      default: c_s = 1'b0;
    endcase
    return c_s;
  endfunction

endpackage

// File: rtl/jt12_acc_cfg_bank.sv
// Double-buffered per-channel configuration: writes land in a pending copy
// and move to the active copy only when the round boundary commits them.
module jt12_acc_cfg_bank
  import jt12_mix_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [2:0] wr_ch,
  input  ch_cfg_t    wr_cfg,
  input  logic       commit,
  input  logic [2:0] rd_ch,
  output ch_cfg_t    rd_cfg,
  output logic       pending
);

  localparam logic [2:0] NUM_CH_W = 3'(NUM_CH);

  ch_cfg_t           active_r  [NUM_CH];
  ch_cfg_t           pending_r [NUM_CH];
  logic [NUM_CH-1:0] dirty_r;

  // Commit clears dirty first; a same-cycle write then re-arms it (write wins)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_r[i]  <= CFG_RESET;
        pending_r[i] <= CFG_RESET;
      end
      dirty_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (commit && dirty_r[i]) begin
          active_r[i] <= pending_r[i];
          dirty_r[i]  <= 1'b0;
        end
        if (we && (wr_ch == 3'(i))) begin
          pending_r[i] <= wr_cfg;
          dirty_r[i]   <= 1'b1;
        end
      end
    end
  end

  // Active config read port for the channel currently on the bus
  always_comb begin
    rd_cfg = CFG_RESET;
    if (rd_ch < NUM_CH_W) begin
      rd_cfg = active_r[rd_ch];
    end else begin
      rd_cfg = CFG_RESET;
    end
  end

  assign pending = |dirty_r;

endmodule

// File: rtl/jt12_acc_sched.sv
// Slot sequencer for the left/right accumulator pair: walks all operator
// slots and derives sum enables, round-start zero and the sample strobe.
module jt12_acc_sched
  import jt12_mix_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       cfg_we,
  input  logic [2:0] cfg_ch,
  input  logic [2:0] cfg_alg,
  input  logic [1:0] cfg_pan,
  input  logic       cfg_mute,
  output logic       cfg_pending,
  output logic [4:0] slot,
  output logic [2:0] ch,
  output logic [1:0] op,
  output logic       sum_en_l,
  output logic       sum_en_r,
  output logic       zero,
  output logic       sample_valid
);

  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);
  localparam logic [4:0] NUM_CH_5  = 5'(NUM_CH);

  logic [4:0] slot_r;
  logic       sample_valid_r;
  logic       commit_s;
  logic       carrier_s;
  ch_cfg_t    wr_cfg_s;
  ch_cfg_t    cfg_s;

  assign wr_cfg_s = '{alg: cfg_alg, pan: cfg_pan, mute: cfg_mute};
  assign commit_s = clk_en & (slot_r == LAST_SLOT);

  jt12_acc_cfg_bank u_cfg_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we),
    .wr_ch   (cfg_ch),
    .wr_cfg  (wr_cfg_s),
    .commit  (commit_s),
    .rd_ch   (ch),
    .rd_cfg  (cfg_s),
    .pending (cfg_pending)
  );

  // Slot counter and sample strobe; both freeze while clk_en is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_r         <= 5'd0;
      sample_valid_r <= 1'b0;
    end else if (clk_en) begin
      slot_r         <= (slot_r == LAST_SLOT) ? 5'd0 : slot_r + 5'd1;
      sample_valid_r <= (slot_r == 5'd0);
    end
  end

  // Per-slot decode from the counter and the active config of its channel
  always_comb begin
    ch        = 3'(slot_r % NUM_CH_5);
    op        = 2'(slot_r / NUM_CH_5);
    carrier_s = is_carrier(cfg_s.alg, op);
    sum_en_l  = carrier_s & cfg_s.pan[1] & ~cfg_s.mute;
    sum_en_r  = carrier_s & cfg_s.pan[0] & ~cfg_s.mute;
  end

  assign slot         = slot_r;
  assign zero         = (slot_r == 5'd0);
  assign sample_valid = sample_valid_r;

endmodule
